// File: rtl/memory_stage.sv
// memory_stage: pipeline memory stage that passes ALU results to writeback or runs one data-memory access with timeout.
module memory_stage #(
  parameter int unsigned TIMEOUT = 15,
  parameter logic [3:0] OP_LOAD = 4'b1100,
  parameter logic [3:0] OP_STORE = 4'b1110
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [4:0]  control_in,
  input  logic [15:0] result_in,
  input  logic [15:0] store_data_in,
  input  logic [4:0]  dest_index_in,
  input  logic        write_enable_in,
  output logic        stall_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_dest,
  output logic [15:0] wb_data,
  output logic [4:0]  wb_control,
  output logic        mem_err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0] state;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic [3:0] op;
  logic       is_mem;
  logic [4:0] pend_dest;
  logic [4:0] pend_ctl;
  assign op = control_in[3:0];
  assign is_mem = op == OP_LOAD || op == OP_STORE;
  assign cnt_nxt = cnt + 8'd1;
  assign stall_out = state == BUSY;
  // dest/control of a memory op are parked so wb_* keep their last values until completion
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      pend_dest <= '0;
      pend_ctl <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      wb_valid <= 1'b0;
      wb_we <= 1'b0;
      wb_dest <= '0;
      wb_data <= '0;
      wb_control <= '0;
      mem_err <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (state == IDLE) begin
        if (valid_in && is_mem) begin
          mem_req <= 1'b1;
          mem_we <= op == OP_STORE;
          mem_addr <= result_in;
          mem_wdata <= store_data_in;
          pend_dest <= dest_index_in;
          pend_ctl <= control_in;
          cnt <= '0;
          state <= BUSY;
        end else if (valid_in) begin
          wb_valid <= 1'b1;
          wb_we <= write_enable_in && op != 4'b0000;
          wb_dest <= dest_index_in;
          wb_data <= result_in;
          wb_control <= control_in;
        end
      end else if (mem_ack || cnt_nxt == 8'(TIMEOUT)) begin
        mem_req <= 1'b0;
        wb_valid <= 1'b1;
        wb_dest <= pend_dest;
        wb_control <= pend_ctl;
        wb_we <= mem_ack && !mem_we;
        wb_data <= !mem_ack ? wb_data : mem_we ? mem_addr : mem_rdata;
        mem_err <= mem_err || !mem_ack;
        state <= IDLE;
      end else
        cnt <= cnt_nxt;
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: randomized transaction-level check of memory_stage against an outcome model.
module tb_memory_stage;
  localparam int T = 15;
  localparam logic [3:0] LD = 4'b1100;
  localparam logic [3:0] ST = 4'b1110;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in = 1'b0;
  logic [4:0] control_in = '0;
  logic [15:0] result_in = '0;
  logic [15:0] store_data_in = '0;
  logic [4:0] dest_index_in = '0;
  logic write_enable_in = 1'b0;
  logic stall_out, mem_req, mem_we, wb_valid, wb_we, mem_err;
  logic [15:0] mem_addr, mem_wdata, wb_data;
  logic [15:0] mem_rdata = '0;
  logic mem_ack = 1'b0;
  logic [4:0] wb_dest, wb_control;
  int checks = 0;
  int passes = 0;
  logic exp_err = 1'b0;
  logic last_we = 1'b0;
  logic [15:0] last_data = '0;
  logic [4:0] last_dest = '0;
  logic [4:0] last_ctl = '0;
  logic [3:0] r_op;
  logic [4:0] r_ctl;
  int r_d;
  memory_stage #(.TIMEOUT(T), .OP_LOAD(LD), .OP_STORE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .control_in(control_in),
    .result_in(result_in), .store_data_in(store_data_in), .dest_index_in(dest_index_in),
    .write_enable_in(write_enable_in), .stall_out(stall_out), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest),
    .wb_data(wb_data), .wb_control(wb_control), .mem_err(mem_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic check_idle(input string tag);
    check({tag, " wb_valid"}, 16'(wb_valid), 16'd0);
    check({tag, " stall"}, 16'(stall_out), 16'd0);
    check({tag, " mem_req"}, 16'(mem_req), 16'd0);
    check({tag, " wb_we"}, 16'(wb_we), 16'(last_we));
    check({tag, " wb_data"}, wb_data, last_data);
    check({tag, " wb_dest"}, 16'(wb_dest), 16'(last_dest));
    check({tag, " mem_err"}, 16'(mem_err), 16'(exp_err));
  endtask
  task automatic idle_cycle(input logic ack);
    valid_in = 1'b0;
    mem_ack = ack;
    mem_rdata = 16'($urandom);
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    check_idle("idle");
  endtask
  // called at a falling edge with the DUT idle; d = cycles without ack before ack appears
  task automatic run_op(input logic [4:0] ctl, input logic [15:0] res, input logic [15:0] sd,
                        input logic [4:0] dest, input logic we, input int d, input logic [15:0] rdata);
    logic [3:0] op;
    bit mem;
    int nb;
    op = ctl[3:0];
    mem = op == LD || op == ST;
    nb = d < T ? d + 1 : T;
    valid_in = 1'b1;
    control_in = ctl;
    result_in = res;
    store_data_in = sd;
    dest_index_in = dest;
    write_enable_in = we;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    if (mem) begin
      for (int c = 1; c <= nb; c++) begin
        check("busy stall", 16'(stall_out), 16'd1);
        check("busy mem_req", 16'(mem_req), 16'd1);
        check("busy mem_addr", mem_addr, res);
        check("busy mem_wdata", mem_wdata, sd);
        check("busy mem_we", 16'(mem_we), 16'(op == ST));
        check("busy wb_valid", 16'(wb_valid), 16'd0);
        check("busy wb_dest", 16'(wb_dest), 16'(last_dest));
        mem_ack = c == d + 1;
        mem_rdata = mem_ack ? rdata : 16'($urandom);
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
      end
      if (d < T) begin
        last_we = op == LD;
        last_data = op == LD ? rdata : res;
      end else begin
        last_we = 1'b0;
        exp_err = 1'b1;
      end
    end else begin
      last_we = op != 4'b0000 && we;
      last_data = res;
    end
    last_dest = dest;
    last_ctl = ctl;
    check("wb_valid", 16'(wb_valid), 16'd1);
    check("wb_we", 16'(wb_we), 16'(last_we));
    check("wb_data", wb_data, last_data);
    check("wb_dest", 16'(wb_dest), 16'(last_dest));
    check("wb_control", 16'(wb_control), 16'(last_ctl));
    check("done stall", 16'(stall_out), 16'd0);
    check("done mem_req", 16'(mem_req), 16'd0);
    check("mem_err", 16'(mem_err), 16'(exp_err));
  endtask
  initial begin
    control_in = 5'b00001;
    result_in = 16'h0042;
    dest_index_in = 5'd3;
    write_enable_in = 1'b1;
    valid_in = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset mem_addr", mem_addr, 16'd0);
    rst_n = 1'b1;
    #1 check("no accept before edge", 16'(wb_valid), 16'd0);
    run_op(5'b00001, 16'h0042, 16'h0, 5'd3, 1'b1, 0, 16'h0);
    idle_cycle(1'b0);
    run_op({1'b0, LD}, 16'h0010, 16'h5555, 5'd7, 1'b0, 3, 16'hBEEF);
    run_op({1'b1, ST}, 16'h0020, 16'h1234, 5'd9, 1'b1, 0, 16'hFFFF);
    run_op({1'b0, LD}, 16'h0030, 16'h0, 5'd4, 1'b1, T - 1, 16'hA5A5);
    run_op(5'b10000, 16'h7777, 16'h0, 5'd5, 1'b1, 0, 16'h0);
    run_op({1'b0, LD}, 16'h0040, 16'h0, 5'd6, 1'b1, 100, 16'h0);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    valid_in = 1'b1;
    control_in = {1'b0, LD};
    result_in = 16'h0050;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pre-reset stall", 16'(stall_out), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    exp_err = 1'b0;
    last_we = 1'b0;
    last_data = '0;
    last_dest = '0;
    last_ctl = '0;
    check_idle("async reset");
    check("async reset mem_addr", mem_addr, 16'd0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    rst_n = 1'b1;
    idle_cycle(1'b1);
    run_op({1'b0, LD}, 16'h0060, 16'h0, 5'd2, 1'b0, 1, 16'hC0DE);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 1) == 0) r_op = $urandom_range(0, 1) == 0 ? LD : ST;
      else begin
        r_op = 4'($urandom);
        while (r_op == LD || r_op == ST) r_op = 4'($urandom);
        if ($urandom_range(0, 4) == 0) r_op = 4'b0000;
      end
      r_ctl = {1'($urandom), r_op};
      r_d = $urandom_range(0, 3) == 0 ? int'($urandom_range(12, 17)) : int'($urandom_range(0, 4));
      run_op(r_ctl, 16'($urandom), 16'($urandom), 5'($urandom), 1'($urandom), r_d, 16'($urandom));
      if ($urandom_range(0, 2) == 0) idle_cycle(1'($urandom));
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
